press_classifier: RTL and testbench

PRESS_CLASSIFIER -- requirements
Module: press_classifier

---
 rtl/press_if.sv | 28 ++
 rtl/press_classifier.sv | 112 +++++++++++
 tb/tb_press_classifier.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/press_if.sv
// Button classifier bus: debounced input level, enable and event outputs.
// master drives pb_state/en, slave returns the classified events.
interface press_if;
  logic en;
  logic pb_state;
  logic short_press;
  logic long_press;
  logic repeat_pulse;
  logic held;

  modport master (
    output en,
    output pb_state,
    input  short_press,
    input  long_press,
    input  repeat_pulse,
    input  held
  );

  modport slave (
    input  en,
    input  pb_state,
    output short_press,
    output long_press,
    output repeat_pulse,
    output held
  );
endinterface

// File: rtl/press_classifier.sv
// Push-button classifier: short press, long press and auto-repeat.
// Acts on a registered copy of the debounced level and its rising edge.
module press_classifier #(
  parameter int LONG_CYC   = 50_000_000,
  parameter int REPEAT_CYC = 10_000_000
) (
  input logic   clk,
  input logic   rst_n,
  press_if.slave bus
);

  localparam int MAXC = (LONG_CYC > REPEAT_CYC) ?
                        LONG_CYC : REPEAT_CYC;
  localparam int CW   = $clog2(MAXC);

  localparam logic [CW-1:0] LTERM = CW'(LONG_CYC - 1);
  localparam logic [CW-1:0] RTERM = CW'(REPEAT_CYC - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PRESSED = 2'd1;
  localparam logic [1:0] S_HELD    = 2'd2;

  logic          pb_q, pb_q2;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sp_q, sp_d;
  logic          lp_q, lp_d;
  logic          rp_q, rp_d;
  logic          held_q;
  logic          rise;

  assign rise = pb_q & ~pb_q2;

  // Next state, counter and event decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sp_d    = 1'b0;
    lp_d    = 1'b0;
    rp_d    = 1'b0;
    if (!bus.en) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (rise) begin
            state_d = S_PRESSED;
            cnt_d   = '0;
          end
        end
        S_PRESSED: begin
          if (!pb_q) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            sp_d    = 1'b1;
          end else if (cnt_q == LTERM) begin
            state_d = S_HELD;
            cnt_d   = '0;
            lp_d    = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_HELD: begin
          if (!pb_q) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else if (cnt_q == RTERM) begin
            cnt_d = '0;
            rp_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Input synchroniser stage, FSM state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pb_q    <= 1'b0;
      pb_q2   <= 1'b0;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sp_q    <= 1'b0;
      lp_q    <= 1'b0;
      rp_q    <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      pb_q    <= bus.pb_state;
      pb_q2   <= pb_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sp_q    <= sp_d;
      lp_q    <= lp_d;
      rp_q    <= rp_d;
      held_q  <= (state_d == S_HELD);
    end
  end

  assign bus.short_press  = sp_q;
  assign bus.long_press   = lp_q;
  assign bus.repeat_pulse = rp_q;
  assign bus.held         = held_q;

endmodule

// File: tb/tb_press_classifier.sv
// Bench for press_classifier with LONG_CYC=8, REPEAT_CYC=4.
// Directed scenarios plus random stimulus against a duration model.
module tb_press_classifier;

  localparam int L = 8;
  localparam int R = 4;

  logic clk;
  logic rst_n;
  press_if bus ();

  press_classifier #(
    .LONG_CYC   (L),
    .REPEAT_CYC (R)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  // Reference model: press age in cycles since the press began.
  bit act;
  int n;
  bit mq1, mq2;
  logic [3:0] expv;
  logic [3:0] prev;
  int c_sp, c_lp, c_rp;

  task automatic model_reset();
    act  = 0;
    n    = 0;
    mq1  = 0;
    mq2  = 0;
    expv = 4'b0;
  endtask

  task automatic model_edge(input bit pb, input bit e);
    bit sp, lp, rp;
    sp = 0;
    lp = 0;
    rp = 0;
    if (!e) begin
      act = 0;
    end else if (act) begin
      if (!mq1) begin
        if (n < L) sp = 1;
        act = 0;
      end else begin
        n++;
        if (n == L) lp = 1;
        else if (n > L && ((n - L) % R) == 0) rp = 1;
      end
    end else if (mq1 && !mq2) begin
      act = 1;
      n   = 0;
    end
    expv = {sp, lp, rp, (act && n >= L)};
    mq2 = mq1;
    mq1 = pb;
  endtask

  function automatic logic [3:0] obs();
    return {bus.short_press, bus.long_press,
            bus.repeat_pulse, bus.held};
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] o,
                     input logic [31:0] x);
    checks++;
    assert (o === x) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, x);
    end
  endtask

  task automatic step(input bit pb, input bit e);
    logic [3:0] o;
    bus.pb_state = pb;
    bus.en       = e;
    @(posedge clk);
    model_edge(pb, e);
    #1;
    o = obs();
    chk("outputs", 32'(o), 32'(expv));
    chk("onehot", 32'($onehot0(o[3:1])), 32'd1);
    chk("no_back2back", 32'(o[3:1] & prev[3:1]), 32'd0);
    c_sp += int'(o[3]);
    c_lp += int'(o[2]);
    c_rp += int'(o[1]);
    prev = o;
  endtask

  task automatic clr();
    c_sp = 0;
    c_lp = 0;
    c_rp = 0;
  endtask

  task automatic press(input int hi, input int lo);
    for (int i = 0; i < hi; i++) step(1'b1, 1'b1);
    for (int i = 0; i < lo; i++) step(1'b0, 1'b1);
  endtask

  initial begin
    int len;
    bit pbv, env;
    prev         = 4'b0;
    bus.pb_state = 1'b0;
    bus.en       = 1'b0;
    rst_n        = 1'b0;
    model_reset();
    clr();
    #12;
    chk("reset_outs", 32'(obs()), 32'd0);
    @(posedge clk);
    #1;
    chk("reset_hold", 32'(obs()), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);

    // short press
    clr();
    press(3, 4);
    chk("short3_sp", c_sp, 1);
    chk("short3_lp", c_lp, 0);

    // long press with repeats
    clr();
    press(20, 4);
    chk("long20_lp", c_lp, 1);
    chk("long20_rp", c_rp, 2);
    chk("long20_sp", c_sp, 0);

    // release on the long terminal edge
    clr();
    press(8, 4);
    chk("edge7_sp", c_sp, 1);
    chk("edge7_lp", c_lp, 0);

    // release on the repeat terminal edge
    clr();
    press(12, 4);
    chk("edge3_lp", c_lp, 1);
    chk("edge3_rp", c_rp, 0);

    // press held across enable rising
    clr();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 15; i++) step(1'b1, 1'b1);
    chk("en_none", c_sp + c_lp + c_rp, 0);
    press(0, 2);
    press(2, 4);
    chk("en_sp", c_sp, 1);

    // reset while held, button kept down
    clr();
    press(12, 0);
    chk("pre_rst_held", 32'(bus.held), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async", 32'(obs()), 32'd0);
    model_reset();
    prev = 4'b0;
    @(posedge clk);
    #1;
    chk("rst_low", 32'(obs()), 32'd0);
    #2;
    rst_n = 1'b1;
    #1;
    chk("rst_release", 32'(obs()), 32'd0);
    clr();
    press(12, 4);
    chk("rst_lp", c_lp, 1);
    chk("rst_sp", c_sp, 0);

    // random durations and enable
    clr();
    for (int k = 0; k < 1500; k++) begin
      len = int'($urandom_range(1, 25));
      pbv = 1'($urandom_range(0, 1));
      env = ($urandom_range(0, 15) != 0);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 63) == 0) env = ~env;
        step(pbv, env);
      end
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
